// File: rtl/mux_n_rr_pkg.sv
// Shared definitions for the N:1 registered multiplexer.
//   mux_mode_e  : channel selection mode (software select or round-robin)
//   clog2_min1  : index width helper, never smaller than 1 bit
package mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_rr_arbiter.sv
// Round-robin arbiter (purely combinational).
//   req  in   N    request vector
//   ptr  in   SW   last granted index; the search starts at ptr+1 (mod N)
//   gnt  out  N    one-hot grant, all zero when no request
//   idx  out  SW   index of the granted request (0 when none)
//   any  out  1    at least one request present
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned SW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] idx,
    output logic          any
);

    always_comb begin
        int unsigned j;
        logic        found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        // k runs 1..N so ptr itself is visited last; a lone requester at
        // ptr is therefore still granted.
        for (int unsigned k = 1; k <= N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = SW'(j);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/mux_n_rr.sv
// N:1 registered multiplexer with valid/ready on every input and the output.
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   N          per-channel valid
//   in_data    in   N*WIDTH    channel i at [i*WIDTH +: WIDTH]
//   in_ready   out  N          per-channel ready (combinational, at most one set)
//   sel        in   SW         channel select, MODE_SEL only
//   out_valid  out  1          registered output valid
//   out_data   out  WIDTH      registered output data
//   out_src    out  SW         channel that supplied out_data
//   out_ready  in   1          downstream ready
module mux_n_rr
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned N     = 4,
    parameter  mux_mode_e   MODE  = MODE_SEL,
    localparam int unsigned SW    = clog2_min1(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    input  logic [SW-1:0]        sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_src,
    input  logic                 out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SW-1:0]    out_src_q,   out_src_d;

    logic             load_en;
    logic             req;
    logic [SW-1:0]    g;
    logic [N-1:0]     gnt_oh;
    logic [WIDTH-1:0] g_data;

    // One-deep output register: refill whenever empty or being drained.
    assign load_en = !out_valid_q || out_ready;

    if (MODE == MODE_RR) begin : g_rr
        logic [SW-1:0] rr_ptr_q, rr_ptr_d;
        logic [N-1:0]  arb_gnt;
        logic [SW-1:0] arb_idx;
        logic          arb_any;
        logic          unused_sel;

        assign unused_sel = ^sel;

        rr_arbiter #(.N(N)) u_arb (
            .req (in_valid),
            .ptr (rr_ptr_q),
            .gnt (arb_gnt),
            .idx (arb_idx),
            .any (arb_any)
        );

        assign req      = arb_any;
        assign g        = arb_idx;
        assign gnt_oh   = arb_gnt;
        assign rr_ptr_d = (load_en && req) ? g : rr_ptr_q;

        // Reset to N-1 so the first search after reset starts at channel 0.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rr_ptr_q <= SW'(N - 1);
            end else begin
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end else begin : g_sel
        logic sel_ok;

        if ((1 << SW) == N) begin : g_pow2
            assign sel_ok = 1'b1;
        end else begin : g_npow2
            assign sel_ok = (32'(sel) < N);
        end

        // Out-of-range selects are folded to 0 so no part-select ever
        // leaves the in_data vector; req stays low for them.
        assign g      = sel_ok ? sel : '0;
        assign req    = sel_ok && in_valid[g];
        assign gnt_oh = req ? (N'(1) << g) : '0;
    end

    assign g_data   = in_data[g*WIDTH +: WIDTH];
    assign in_ready = (rst_n && load_en) ? gnt_oh : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (load_en) begin
            out_valid_d = req;
            if (req) begin
                out_data_d = g_data;
                out_src_d  = g;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_n_rr.sv
module tb_mux_n_rr;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // N=4 software select
    logic [3:0]  s4_iv, s4_ir;
    logic [31:0] s4_id;
    logic [1:0]  s4_sel, s4_src;
    logic        s4_ov, s4_or;
    logic [7:0]  s4_od;
    // N=4 round-robin
    logic [3:0]  r4_iv, r4_ir;
    logic [31:0] r4_id;
    logic [1:0]  r4_sel, r4_src;
    logic        r4_ov, r4_or;
    logic [7:0]  r4_od;
    // N=3 software select
    logic [2:0]  s3_iv, s3_ir;
    logic [23:0] s3_id;
    logic [1:0]  s3_sel, s3_src;
    logic        s3_ov, s3_or;
    logic [7:0]  s3_od;

    mux_n_rr #(.WIDTH(8), .N(4), .MODE(MODE_SEL)) u_sel4 (
        .clk(clk), .rst_n(rst_n), .in_valid(s4_iv), .in_data(s4_id), .in_ready(s4_ir),
        .sel(s4_sel), .out_valid(s4_ov), .out_data(s4_od), .out_src(s4_src), .out_ready(s4_or));

    mux_n_rr #(.WIDTH(8), .N(4), .MODE(MODE_RR)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_valid(r4_iv), .in_data(r4_id), .in_ready(r4_ir),
        .sel(r4_sel), .out_valid(r4_ov), .out_data(r4_od), .out_src(r4_src), .out_ready(r4_or));

    mux_n_rr #(.WIDTH(8), .N(3), .MODE(MODE_SEL)) u_sel3 (
        .clk(clk), .rst_n(rst_n), .in_valid(s3_iv), .in_data(s3_id), .in_ready(s3_ir),
        .sel(s3_sel), .out_valid(s3_ov), .out_data(s3_od), .out_src(s3_src), .out_ready(s3_or));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard on the round-robin instance plus one-hot in_ready on all.
    logic [9:0] sb[$];
    always @(posedge clk) begin
        logic [9:0] e;
        chk("s4_ir_onehot", 32'($onehot0(s4_ir)), 32'd1);
        chk("r4_ir_onehot", 32'($onehot0(r4_ir)), 32'd1);
        chk("s3_ir_onehot", 32'($onehot0(s3_ir)), 32'd1);
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (r4_ov && r4_or) begin
                e = (sb.size() != 0) ? sb.pop_front() : 10'h3FF;
                chk("sb_beat", 32'({r4_src, r4_od}), 32'(e));
            end
            for (int i = 0; i < 4; i++)
                if (r4_iv[i] && r4_ir[i]) sb.push_back({2'(i), r4_id[i*8 +: 8]});
        end
    end

    initial begin
        s4_iv = 4'b0001; s4_id = '0; s4_sel = '0; s4_or = 1'b1;
        r4_iv = '0;      r4_id = '0; r4_sel = '0; r4_or = 1'b0;
        s3_iv = '0;      s3_id = '0; s3_sel = '0; s3_or = 1'b0;

        // Reset state; s4 has a request pending but must not be ready.
        repeat (2) @(negedge clk);
        chk("rst_s4_ov",  32'(s4_ov),  32'd0);
        chk("rst_s4_od",  32'(s4_od),  32'd0);
        chk("rst_s4_src", 32'(s4_src), 32'd0);
        chk("rst_s4_ir",  32'(s4_ir),  32'd0);
        chk("rst_r4_ov",  32'(r4_ov),  32'd0);
        chk("rst_s3_ov",  32'(s3_ov),  32'd0);

        // 1: MODE_SEL basic transfer
        rst_n = 1'b1;
        s4_sel = 2'd2; s4_iv = 4'b0100; s4_id = 32'h44A5_2211; s4_or = 1'b1;
        #1 chk("t1_ir", 32'(s4_ir), 32'h4);
        @(negedge clk);
        chk("t1_ov",  32'(s4_ov),  32'd1);
        chk("t1_od",  32'(s4_od),  32'hA5);
        chk("t1_src", 32'(s4_src), 32'd2);

        // 2: stall, with in_data and sel changing underneath the held beat
        s4_or = 1'b0; s4_sel = 2'd1; s4_iv = 4'b0110;
        #1 chk("t2_ir_stall0", 32'(s4_ir), 32'd0);
        for (int k = 0; k < 3; k++) begin
            s4_id = {8'h44, 8'(8'h60 + k), 8'(8'h70 + k), 8'h11};
            @(negedge clk);
            chk("t2_hold_od",  32'(s4_od),  32'hA5);
            chk("t2_hold_src", 32'(s4_src), 32'd2);
            chk("t2_hold_ov",  32'(s4_ov),  32'd1);
            chk("t2_hold_ir",  32'(s4_ir),  32'd0);
        end
        s4_id = 32'h44C3_9611; s4_or = 1'b1;
        #1 chk("t2_ir_release", 32'(s4_ir), 32'h2);
        @(negedge clk);
        chk("t2_od",  32'(s4_od),  32'h96);
        chk("t2_src", 32'(s4_src), 32'd1);
        chk("t2_ov",  32'(s4_ov),  32'd1);
        s4_iv = '0;
        @(negedge clk);
        chk("t2_idle_ov",  32'(s4_ov),  32'd0);
        chk("t2_idle_od",  32'(s4_od),  32'h96);
        chk("t2_idle_src", 32'(s4_src), 32'd1);

        // 3: RR, all channels requesting
        r4_or = 1'b1; r4_id = 32'h1312_1110; r4_iv = 4'b1111;
        #1 chk("t3_ir", 32'(r4_ir), 32'h1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t3_src", 32'(r4_src), 32'(k % 4));
            chk("t3_od",  32'(r4_od),  32'(8'h10 + k % 4));
            chk("t3_ov",  32'(r4_ov),  32'd1);
        end

        // 4: RR with channels 1 and 3, then channel 1 alone
        r4_iv = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_src", 32'(r4_src), (k % 2 == 1) ? 32'd3 : 32'd1);
            chk("t4_od",  32'(r4_od),  (k % 2 == 1) ? 32'h13 : 32'h11);
        end
        r4_iv = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_lone_src", 32'(r4_src), 32'd1);
            chk("t4_lone_ov",  32'(r4_ov),  32'd1);
        end

        // 5: N=3, out-of-range select
        s3_or = 1'b1; s3_sel = 2'd3; s3_iv = 3'b111; s3_id = 24'hC2B1A0;
        #1 chk("t5_ir", 32'(s3_ir), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t5_ov",  32'(s3_ov),  32'd0);
            chk("t5_od",  32'(s3_od),  32'd0);
            chk("t5_src", 32'(s3_src), 32'd0);
        end
        s3_sel = 2'd2;
        #1 chk("t5_ir_ok", 32'(s3_ir), 32'h4);
        @(negedge clk);
        chk("t5_od_ok",  32'(s3_od),  32'hC2);
        chk("t5_src_ok", 32'(s3_src), 32'd2);
        s3_iv = '0;

        // 6: asynchronous reset mid-stream on the RR instance
        r4_iv = 4'b1111;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_ov_async", 32'(r4_ov), 32'd0);
        chk("t6_ir_async", 32'(r4_ir), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("t6_ir_first", 32'(r4_ir), 32'h1);
        @(negedge clk);
        chk("t6_src0", 32'(r4_src), 32'd0);
        chk("t6_od0",  32'(r4_od),  32'h10);
        @(negedge clk);
        chk("t6_src1", 32'(r4_src), 32'd1);

        r4_iv = '0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
